// File: rtl/rs_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : rs_issue_sched
// Brief   : Reservation-station entry allocator and oldest-ready issue selector.
// Revision: 1.0  initial release
// ============================================================================
module rs_issue_sched #(
    parameter int RS_NUM = 16,
    parameter int IDX_W  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              clr,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [IDX_W-1:0]  alloc_idx,
    output logic              full,
    output logic              empty,
    output logic [IDX_W:0]    count,
    input  logic [RS_NUM-1:0] ready_vec,
    input  logic              ex_busy,
    output logic              issue_en,
    output logic [IDX_W-1:0]  issue_idx
);

    logic [RS_NUM-1:0]             occupied_q, occupied_d;
    logic [RS_NUM-1:0][RS_NUM-1:0] older_q, older_d;
    logic                          full_q, empty_q, issue_en_q;
    logic [IDX_W:0]                count_q, count_d;
    logic [IDX_W-1:0]              issue_idx_q;

    logic [RS_NUM-1:0]             cand;
    logic [IDX_W-1:0]              win_idx;
    logic                          blocked;
    logic                          issue_fire;

    always_comb begin
        alloc_idx = '0;
        for (int i = RS_NUM - 1; i >= 0; i--) begin
            if (!occupied_q[i]) alloc_idx = IDX_W'(i);
        end
    end

    assign alloc_gnt = alloc_req & ~full_q & rdy & ~rst & ~clr;

    // An entry wins when no other candidate is older than it.
    assign cand = ready_vec & occupied_q;
    always_comb begin
        win_idx = '0;
        blocked = 1'b0;
        for (int i = 0; i < RS_NUM; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < RS_NUM; j++) begin
                blocked = blocked | (cand[j] & older_q[j][i]);
            end
            if (cand[i] && !blocked) win_idx = IDX_W'(i);
        end
    end

    assign issue_fire = rdy & ~ex_busy & (|cand);

    always_comb begin
        occupied_d = occupied_q;
        older_d    = older_q;
        if (issue_fire) begin
            occupied_d[win_idx] = 1'b0;
            for (int k = 0; k < RS_NUM; k++) older_d[k][win_idx] = 1'b0;
        end
        if (alloc_gnt) begin
            occupied_d[alloc_idx] = 1'b1;
            older_d[alloc_idx]    = '0;
            for (int k = 0; k < RS_NUM; k++) older_d[k][alloc_idx] = occupied_q[k];
        end
    end

    always_comb begin
        count_d = '0;
        for (int i = 0; i < RS_NUM; i++) count_d = count_d + (IDX_W+1)'(occupied_d[i]);
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            occupied_q  <= '0;
            older_q     <= '0;
            issue_en_q  <= 1'b0;
            issue_idx_q <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
        end else if (rdy) begin
            occupied_q <= occupied_d;
            older_q    <= older_d;
            count_q    <= count_d;
            full_q     <= (count_d == (IDX_W+1)'(RS_NUM));
            empty_q    <= (count_d == '0);
            issue_en_q <= issue_fire;
            if (issue_fire) issue_idx_q <= win_idx;
        end
    end

    assign full      = full_q;
    assign empty     = empty_q;
    assign count     = count_q;
    assign issue_en  = issue_en_q;
    assign issue_idx = issue_idx_q;

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst && !clr) begin
            for (int i = 0; i < RS_NUM; i++) begin
                assert (!older_q[i][i]);
                for (int j = 0; j < RS_NUM; j++) begin
                    if (i != j && occupied_q[i] && occupied_q[j])
                        assert (older_q[i][j] ^ older_q[j][i]);
                end
            end
            if (issue_fire) assert (occupied_q[win_idx]);
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_rs_issue_sched.sv
`default_nettype none
// ============================================================================
// Module  : tb_rs_issue_sched
// Brief   : Directed scoreboard bench for rs_issue_sched.
// Revision: 1.0  initial release
// ============================================================================
module tb_rs_issue_sched;

    localparam int RS_NUM = 16;
    localparam int IDX_W  = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              rdy = 1'b1;
    logic              clr = 1'b0;
    logic              alloc_req = 1'b0;
    logic              alloc_gnt;
    logic [IDX_W-1:0]  alloc_idx;
    logic              full, empty;
    logic [IDX_W:0]    count;
    logic [RS_NUM-1:0] ready_vec = '0;
    logic              ex_busy = 1'b0;
    logic              issue_en;
    logic [IDX_W-1:0]  issue_idx;

    int n_chk  = 0;
    int n_fail = 0;
    int exp_q[$];

    rs_issue_sched #(.RS_NUM(RS_NUM), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clr(clr),
        .alloc_req(alloc_req), .alloc_gnt(alloc_gnt), .alloc_idx(alloc_idx),
        .full(full), .empty(empty), .count(count),
        .ready_vec(ready_vec), .ex_busy(ex_busy),
        .issue_en(issue_en), .issue_idx(issue_idx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Monitor: an issue is new only if rdy was high and no reset/flush at that edge.
    always @(posedge clk) begin
        logic rdy_s, rst_s;
        int   e;
        rdy_s = rdy;
        rst_s = rst | clr;
        #2;
        if (issue_en && rdy_s && !rst_s) begin
            n_chk++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue_unexpected: got idx %0d expected no issue", issue_idx);
            end else begin
                e = exp_q.pop_front();
                if (int'(issue_idx) != e) begin
                    n_fail++;
                    $display("FAIL issue_idx: got %0d expected %0d", issue_idx, e);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset and idle
        step(2);
        rst = 1'b0;
        step(1);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_issue_en", int'(issue_en), 0);
        chk("rst_alloc_idx", int'(alloc_idx), 0);

        // Three allocations, then in-order drain
        alloc_req = 1'b1;
        #1;
        chk("t2_gnt", int'(alloc_gnt), 1);
        for (int i = 0; i < 3; i++) begin
            chk("t2_alloc_idx", int'(alloc_idx), i);
            step(1);
        end
        alloc_req = 1'b0;
        chk("t2_count3", int'(count), 3);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2);
        ready_vec = 16'h0007;
        step(1);
        chk("t2_count2", int'(count), 2);
        step(2);
        chk("t2_count0", int'(count), 0);
        chk("t2_empty", int'(empty), 1);
        ready_vec = '0;

        // Reuse freed slot 0; age order must put it last
        alloc_req = 1'b1;
        step(3);
        alloc_req = 1'b0;
        ready_vec = 16'h0001;
        exp_q.push_back(0);
        step(1);
        ready_vec = '0;
        alloc_req = 1'b1;
        #1;
        chk("t3_realloc_idx", int'(alloc_idx), 0);
        step(1);
        alloc_req = 1'b0;
        ready_vec = 16'h0007;
        exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        step(3);
        ready_vec = '0;
        chk("t3_empty", int'(empty), 1);

        // Fill to full, issue 5, reallocate 5
        alloc_req = 1'b1;
        step(16);
        chk("t4_count16", int'(count), 16);
        chk("t4_full", int'(full), 1);
        ready_vec = 16'h0020;
        exp_q.push_back(5);
        #1;
        chk("t4_gnt_full", int'(alloc_gnt), 0);
        step(1);
        ready_vec = '0;
        #1;
        chk("t4_gnt_after", int'(alloc_gnt), 1);
        chk("t4_alloc_idx5", int'(alloc_idx), 5);
        step(1);
        alloc_req = 1'b0;
        chk("t4_full_again", int'(full), 1);
        chk("t4_count_again", int'(count), 16);

        // EX busy stall, release, then rdy freeze
        ex_busy = 1'b1;
        ready_vec = 16'hFFFF;
        repeat (4) begin
            step(1);
            chk("t5_busy_no_issue", int'(issue_en), 0);
        end
        chk("t5_busy_count", int'(count), 16);
        ex_busy = 1'b0;
        exp_q.push_back(0);
        step(1);
        chk("t5_rel_issue_en", int'(issue_en), 1);
        chk("t5_rel_issue_idx", int'(issue_idx), 0);
        rdy = 1'b0;
        alloc_req = 1'b1;
        #1;
        chk("t5_frz_gnt", int'(alloc_gnt), 0);
        repeat (3) begin
            step(1);
            chk("t5_frz_issue_en", int'(issue_en), 1);
            chk("t5_frz_issue_idx", int'(issue_idx), 0);
            chk("t5_frz_count", int'(count), 15);
        end
        alloc_req = 1'b0;
        rdy = 1'b1;
        for (int i = 1; i < 16; i++) if (i != 5) exp_q.push_back(i);
        exp_q.push_back(5);
        step(15);
        ready_vec = '0;
        chk("t5_drain_count", int'(count), 0);
        chk("t5_drain_empty", int'(empty), 1);

        // Flush while allocating and issuing
        alloc_req = 1'b1;
        step(8);
        chk("t6_count8", int'(count), 8);
        clr = 1'b1;
        ready_vec = 16'hFFFF;
        #1;
        chk("t6_clr_gnt", int'(alloc_gnt), 0);
        step(1);
        clr = 1'b0;
        alloc_req = 1'b0;
        ready_vec = '0;
        chk("t6_count0", int'(count), 0);
        chk("t6_empty", int'(empty), 1);
        chk("t6_full", int'(full), 0);
        chk("t6_issue_en", int'(issue_en), 0);
        step(3);
        chk("scoreboard_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
